// File: rtl/uart8_tx_fifo.sv
// Byte FIFO and launch sequencer feeding a Uart8 transmitter (txStart/in, txBusy/txDone handshake).
// Optional: define UART8_TX_FIFO_OVERFLOW_EN for a sticky overflow flag and write-through-pop when full.
module uart8_tx_fifo #(
  parameter int DEPTH         = 16,
  parameter int START_TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wrValid,
  input  logic [7:0]               wrData,
  output logic                     wrReady,
  output logic                     txStart,
  output logic [7:0]               txByte,
  input  logic                     txBusy,
  input  logic                     txDone,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     timeoutErr,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, SEND, GAP} state_t;

  state_t          state, state_n;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [TW-1:0]   timer;
  logic            done_q;
  logic            done_rise;
  logic            full;
  logic            push, pop;
  logic            launch, drop_start, tmo, tmr_inc;

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign done_rise = txDone && !done_q;
  assign push      = wrValid && wrReady;

`ifdef UART8_TX_FIFO_OVERFLOW_EN
  // A pop frees the head slot on the same edge, so a full FIFO can take a byte then.
  assign wrReady = !full || pop;

  always_ff @(posedge clk) begin
    if (reset)
      overflow <= 1'b0;
    else if (wrValid && !wrReady)
      overflow <= 1'b1;
  end
`else
  assign wrReady  = !full;
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset && push)
      mem[wr_ptr] <= wrData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    launch     = 1'b0;
    drop_start = 1'b0;
    tmo        = 1'b0;
    tmr_inc    = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          launch  = 1'b1;
          state_n = LAUNCH;
        end
      end
      LAUNCH: begin
        if (txBusy) begin
          drop_start = 1'b1;
          state_n    = SEND;
        end else if (timer == TW'(START_TIMEOUT - 1)) begin
          // Head stays put; IDLE relaunches the same byte.
          drop_start = 1'b1;
          tmo        = 1'b1;
          state_n    = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      SEND: begin
        if (done_rise) begin
          pop     = 1'b1;
          state_n = GAP;
        end
      end
      GAP: begin
        // Uart8 may hold done/busy for a while; relaunching early would double-send.
        if (!txBusy && !txDone)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      txStart    <= 1'b0;
      txByte     <= 8'h00;
      timer      <= '0;
      timeoutErr <= 1'b0;
    end else begin
      state      <= state_n;
      done_q     <= txDone;
      timeoutErr <= tmo;
      if (launch) begin
        txByte  <= mem[rd_ptr];
        txStart <= 1'b1;
        timer   <= '0;
      end else begin
        if (drop_start) txStart <= 1'b0;
        if (tmr_inc)    timer   <= timer + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart8_tx_fifo.sv
// Self-checking bench for uart8_tx_fifo: behavioural Uart8 stand-in plus a queue/count reference model.
module tb_uart8_tx_fifo;
  localparam int DEPTH = 16;
  localparam int TMO   = 64;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, wrValid, wrReady, txStart, txBusy, txDone, empty, timeoutErr, overflow;
  logic [7:0]    wrData, txByte;
  logic [LW-1:0] level;

  int checks = 0, errors = 0;
  int lvl_m = 0, rises = 0;
  logic [7:0] exp_q[$], rx_q[$];
  bit rdy_seen, rdy_exp, ts_prev;

  // Uart8 stand-in knobs and state
  int u_st = 0, u_cnt = 0, u_lat = 1, u_frame = 10, u_hold = 1;
  bit u_en = 1'b1, u_done_rise = 1'b0;
  logic [7:0] u_byte;

  uart8_tx_fifo #(.DEPTH(DEPTH), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .wrValid(wrValid), .wrData(wrData), .wrReady(wrReady),
    .txStart(txStart), .txByte(txByte), .txBusy(txBusy), .txDone(txDone),
    .level(level), .empty(empty), .timeoutErr(timeoutErr), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Uart8 transmitter: sees txStart, goes busy, then raises done for u_hold+1 cycles.
  always @(negedge clk) begin
    u_done_rise = 1'b0;
    case (u_st)
      0: if (txStart && u_en) begin u_byte = txByte; u_cnt = u_lat; u_st = 1; end
      1: if (u_cnt == 0) begin txBusy = 1'b1; u_cnt = u_frame; u_st = 2; end else u_cnt--;
      2: if (u_cnt == 0) begin
           txBusy = 1'b0; txDone = 1'b1; u_done_rise = 1'b1;
           rx_q.push_back(u_byte); u_cnt = u_hold; u_st = 3;
         end else u_cnt--;
      default: if (u_cnt == 0) begin txDone = 1'b0; u_st = 0; end else u_cnt--;
    endcase
  end

  // One clock of stimulus plus reference-model update; no comparisons here.
  task automatic step(input bit v, input logic [7:0] d, output bit acc);
    bit pop_m, rdy_m;
    @(negedge clk);
    wrValid = v; wrData = d;
    #2;
    pop_m = u_done_rise;
    rdy_m = (lvl_m < DEPTH);
`ifdef UART8_TX_FIFO_OVERFLOW_EN
    rdy_m = rdy_m || pop_m;
`endif
    rdy_exp  = rdy_m;
    rdy_seen = wrReady;
    acc = v && rdy_m;
    @(posedge clk); #1;
    if (acc) exp_q.push_back(d);
    lvl_m = lvl_m + int'(acc) - int'(pop_m);
    if (txStart && !ts_prev) rises++;
    ts_prev = txStart;
  endtask

  task automatic drain(input int budget, output bit ok);
    bit a;
    int n = 0;
    while (!(lvl_m == 0 && u_st == 0) && n < budget) begin step(1'b0, 8'h00, a); n++; end
    ok = (lvl_m == 0 && u_st == 0);
  endtask

  task automatic test_reset;
    bit a;
    reset = 1'b1; wrValid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    lvl_m = 0;
    repeat (20) step(1'b0, 8'h00, a);
    checks++; if (txStart !== 1'b0)    begin errors++; $display("FAIL reset_txStart got %b want 0", txStart); end
    checks++; if (txByte !== 8'h00)    begin errors++; $display("FAIL reset_txByte got %h want 00", txByte); end
    checks++; if (level !== '0)        begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (wrReady !== 1'b1)    begin errors++; $display("FAIL reset_wrReady got %b want 1", wrReady); end
    checks++; if (timeoutErr !== 1'b0) begin errors++; $display("FAIL reset_timeoutErr got %b want 0", timeoutErr); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_single;
    bit a, ok;
    u_en = 1'b1; u_lat = 1; u_frame = 10; u_hold = 2;
    exp_q.delete(); rx_q.delete();
    step(1'b1, 8'd30, a);
    checks++; if (txStart !== 1'b0)      begin errors++; $display("FAIL single_early_start got %b want 0", txStart); end
    checks++; if (level !== LW'(lvl_m)) begin errors++; $display("FAIL single_level got %0d want %0d", level, lvl_m); end
    step(1'b0, 8'h00, a);
    checks++; if (txStart !== 1'b1)      begin errors++; $display("FAIL single_start got %b want 1", txStart); end
    checks++; if (txByte !== 8'd30)      begin errors++; $display("FAIL single_txByte got %0d want 30", txByte); end
    drain(500, ok);
    checks++; if (!ok)                   begin errors++; $display("FAIL single_drain_timeout got lvl_m=%0d want 0", lvl_m); end
    checks++; if (level !== '0)          begin errors++; $display("FAIL single_level_end got %0d want 0", level); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'd30)
      begin errors++; $display("FAIL single_rx got size %0d want one byte 30", rx_q.size()); end
  endtask

  task automatic test_burst;
    logic [7:0] list [20] = '{8'd30, 8'd24, 8'd19, 8'd25, 8'd91, 8'd77, 8'd1, 8'd0, 8'd99, 8'd15,
                              8'd100, 8'd128, 8'd255, 8'd254, 8'd0, 8'd10, 8'd43, 8'd149, 8'd7, 8'd2};
    bit a, ok;
    int i = 0, n = 0, first_rej = -1, r0;
    u_en = 1'b1; u_lat = 1; u_frame = 40; u_hold = 1;
    exp_q.delete(); rx_q.delete();
    r0 = rises;
    while (i < 20 && n < 2000) begin
      step(1'b1, list[i], a);
      checks++; if (rdy_seen !== rdy_exp) begin errors++; $display("FAIL burst_wrReady got %b want %b", rdy_seen, rdy_exp); end
      checks++; if (level !== LW'(lvl_m)) begin errors++; $display("FAIL burst_level got %0d want %0d", level, lvl_m); end
      if (a) i++; else if (first_rej < 0) first_rej = i;
      n++;
    end
    checks++; if (first_rej != 16) begin errors++; $display("FAIL burst_full_at got %0d want 16", first_rej); end
    drain(6000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_drain_timeout got lvl_m=%0d want 0", lvl_m); end
    checks++; if (rx_q.size() != 20) begin errors++; $display("FAIL burst_rx_count got %0d want 20", rx_q.size()); end
    else for (int k = 0; k < 20; k++) begin
      checks++; if (rx_q[k] !== list[k]) begin errors++; $display("FAIL burst_rx[%0d] got %0d want %0d", k, rx_q[k], list[k]); end
    end
    checks++; if (rises - r0 != 20) begin errors++; $display("FAIL burst_start_edges got %0d want 20", rises - r0); end
  endtask

  task automatic test_timeout;
    bit a, ok;
    int n = 0, cnt = 0;
    u_en = 1'b0; u_lat = 0; u_frame = 6; u_hold = 1;
    exp_q.delete(); rx_q.delete();
    step(1'b1, 8'hA5, a);
    while (txStart !== 1'b1 && n < 10) begin step(1'b0, 8'h00, a); n++; end
    while (timeoutErr !== 1'b1 && cnt < 200) begin step(1'b0, 8'h00, a); cnt++; end
    checks++; if (cnt != TMO) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", cnt, TMO); end
    checks++; if (level !== LW'(1)) begin errors++; $display("FAIL timeout_level got %0d want 1", level); end
    step(1'b0, 8'h00, a);
    checks++; if (timeoutErr !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width got %b want 0", timeoutErr); end
    checks++; if (level !== LW'(1)) begin errors++; $display("FAIL timeout_level_after got %0d want 1", level); end
    u_en = 1'b1;
    drain(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_drain got lvl_m=%0d want 0", lvl_m); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5)
      begin errors++; $display("FAIL timeout_rx got size %0d want one byte A5", rx_q.size()); end
    checks++; if (level !== '0) begin errors++; $display("FAIL timeout_level_end got %0d want 0", level); end
  endtask

  task automatic test_done_hold;
    bit a, pend = 1'b0, prev_done = 1'b0;
    int n = 0, r0;
    u_en = 1'b1; u_lat = 0; u_frame = 8; u_hold = 49;
    exp_q.delete(); rx_q.delete();
    r0 = rises;
    for (int k = 0; k < 3; k++) step(1'b1, 8'($urandom), a);
    while (!(lvl_m == 0 && u_st == 0) && n < 2000) begin
      step(1'b0, 8'h00, a);
      checks++; if (txStart && txDone) begin errors++; $display("FAIL hold_relaunch got txStart=1 with txDone=1 want 0"); end
      checks++; if (level !== LW'(lvl_m)) begin errors++; $display("FAIL hold_level got %0d want %0d", level, lvl_m); end
      if (pend) begin
        checks++; if (txStart !== 1'b1) begin errors++; $display("FAIL hold_gap_start got %b want 1", txStart); end
        pend = 1'b0;
      end
      if (prev_done && !txDone && lvl_m > 0) begin
        checks++; if (txStart !== 1'b0) begin errors++; $display("FAIL hold_gap_early got %b want 0", txStart); end
        pend = 1'b1;
      end
      prev_done = txDone;
      n++;
    end
    checks++; if (rises - r0 != 3) begin errors++; $display("FAIL hold_start_edges got %0d want 3", rises - r0); end
    checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL hold_rx_count got %0d want 3", rx_q.size()); end
    else for (int k = 0; k < 3; k++) begin
      checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL hold_rx[%0d] got %h want %h", k, rx_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_mid;
    bit a;
    int n = 0;
    u_en = 1'b1; u_lat = 1; u_frame = 30; u_hold = 2;
    step(1'b1, 8'h11, a);
    step(1'b1, 8'h22, a);
    while (u_st != 2 && n < 50) begin step(1'b0, 8'h00, a); n++; end
    @(negedge clk); reset = 1'b1; wrValid = 1'b0;
    @(posedge clk); #1;
    checks++; if (level !== '0)     begin errors++; $display("FAIL rstmid_level got %0d want 0", level); end
    checks++; if (txStart !== 1'b0) begin errors++; $display("FAIL rstmid_txStart got %b want 0", txStart); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL rstmid_empty got %b want 1", empty); end
    @(negedge clk); reset = 1'b0;
    n = 0;
    while (u_st != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #3;
    lvl_m = 0; exp_q.delete(); rx_q.delete(); ts_prev = txStart;
    checks++; if (level !== '0)     begin errors++; $display("FAIL rstmid_level_after got %0d want 0", level); end
    checks++; if (txStart !== 1'b0) begin errors++; $display("FAIL rstmid_no_relaunch got %b want 0", txStart); end
  endtask

  task automatic test_overflow;
    bit a, ok, ov_exp;
`ifdef UART8_TX_FIFO_OVERFLOW_EN
    ov_exp = 1'b1;
`else
    ov_exp = 1'b0;
`endif
    u_en = 1'b0; u_lat = 0; u_frame = 6; u_hold = 1;
    exp_q.delete(); rx_q.delete();
    for (int k = 0; k < DEPTH; k++) step(1'b1, 8'($urandom_range(0, 200)), a);
    checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_fill_level got %0d want %0d", level, DEPTH); end
    step(1'b1, 8'hEE, a);
    checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL ovf_wrReady got %b want 0", rdy_seen); end
    checks++; if (overflow !== ov_exp) begin errors++; $display("FAIL ovf_flag got %b want %b", overflow, ov_exp); end
    checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_level got %0d want %0d", level, DEPTH); end
    repeat (3) step(1'b0, 8'h00, a);
    checks++; if (overflow !== ov_exp) begin errors++; $display("FAIL ovf_sticky got %b want %b", overflow, ov_exp); end
    u_en = 1'b1;
    drain(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_drain got lvl_m=%0d want 0", lvl_m); end
    checks++; if (rx_q.size() != DEPTH) begin errors++; $display("FAIL ovf_rx_count got %0d want %0d", rx_q.size(), DEPTH); end
    else for (int k = 0; k < DEPTH; k++) begin
      checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL ovf_rx[%0d] got %h want %h", k, rx_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_random;
    bit a, ok;
    u_en = 1'b1;
    exp_q.delete(); rx_q.delete();
    for (int k = 0; k < 400; k++) begin
      u_lat = $urandom_range(0, 3); u_frame = $urandom_range(2, 15); u_hold = $urandom_range(0, 4);
      step($urandom_range(0, 2) != 0, 8'($urandom), a);
      checks++; if (level !== LW'(lvl_m)) begin errors++; $display("FAIL rand_level got %0d want %0d", level, lvl_m); end
      checks++; if (empty !== (lvl_m == 0)) begin errors++; $display("FAIL rand_empty got %b want %b", empty, lvl_m == 0); end
      checks++; if (rdy_seen !== rdy_exp) begin errors++; $display("FAIL rand_wrReady got %b want %b", rdy_seen, rdy_exp); end
      checks++; if (txStart && txDone) begin errors++; $display("FAIL rand_relaunch got txStart=1 with txDone=1 want 0"); end
    end
    drain(8000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_drain got lvl_m=%0d want 0", lvl_m); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_rx_count got %0d want %0d", rx_q.size(), exp_q.size()); end
    else for (int k = 0; k < exp_q.size(); k++) begin
      checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_rx[%0d] got %h want %h", k, rx_q[k], exp_q[k]); end
    end
  endtask

  initial begin
    reset = 1'b1; wrValid = 1'b0; wrData = 8'h00;
    txBusy = 1'b0; txDone = 1'b0; ts_prev = 1'b0;
    test_reset;
    test_single;
    test_burst;
    test_timeout;
    test_done_hold;
    test_reset_mid;
    test_overflow;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
